// File: rtl/mul_iter_pkg.sv
// Shared definitions for the iterative RV32M multiplier: op codes, FSM states, iteration count.
package mul_iter_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam int unsigned MUL_ITERS = 32;
    localparam int unsigned CNT_W     = $clog2(MUL_ITERS);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } mul_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_neg);
        return is_neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_iter_add.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with a group-level carry chain.
module mul_iter_add (
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] s
);

    logic [31:0] g;
    logic [31:0] p;

    assign g = x & y;
    assign p = x ^ y;

    always_comb begin
        logic [7:0]  gg;
        logic [7:0]  gp;
        logic [8:0]  cg;
        logic [32:0] c;
        gg = '0;
        gp = '0;
        cg = '0;
        c  = '0;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            cg[k+1] = gg[k] | (gp[k] & cg[k]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k] = cg[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        s = p ^ c[31:0];
    end

endmodule

// File: rtl/mul_iter.sv
// Radix-2 shift-add RV32M multiplier: one partial product per cycle, sign fix-up, held result.
module mul_iter
    import mul_iter_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag
);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             fix_q;
    logic [1:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             neg_q;
    logic [31:0]      amag_q;
    logic [63:0]      p_q;
    logic [31:0]      res_data_q;
    logic [TAG_W-1:0] res_tag_q;

    logic        a_neg, b_neg;
    logic [31:0] addend, sum;
    logic        cout;
    logic [63:0] p_step;

    assign a_neg = req_a[31] & ((req_op == MUL_OP_MULH) | (req_op == MUL_OP_MULHSU));
    assign b_neg = req_b[31] & (req_op == MUL_OP_MULH);

    assign addend = p_q[0] ? amag_q : 32'd0;

    mul_iter_add u_add (
        .x (p_q[63:32]),
        .y (addend),
        .s (sum)
    );

    assign cout   = (p_q[63] & addend[31]) | ((p_q[63] ^ addend[31]) & ~sum[31]);
    assign p_step = {cout, sum, p_q[31:1]};

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_valid) state_d = StRun;
            StRun:  if (cnt_q == CNT_W'(MUL_ITERS - 1)) state_d = StFix;
            StFix:  if (fix_q) state_d = StDone;
            StDone: if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        res_valid = (state_q == StDone);
    end

    // FIX spends its first cycle negating P and its second latching the selected word.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            cnt_q      <= '0;
            fix_q      <= 1'b0;
            op_q       <= '0;
            tag_q      <= '0;
            neg_q      <= 1'b0;
            amag_q     <= '0;
            p_q        <= '0;
            res_data_q <= '0;
            res_tag_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        tag_q  <= req_tag;
                        neg_q  <= a_neg ^ b_neg;
                        amag_q <= mag32(req_a, a_neg);
                        p_q    <= {32'd0, mag32(req_b, b_neg)};
                        cnt_q  <= '0;
                        fix_q  <= 1'b0;
                    end
                end
                StRun: begin
                    p_q   <= p_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                StFix: begin
                    if (!fix_q) begin
                        if (neg_q) p_q <= ~p_q + 64'd1;
                        fix_q <= 1'b1;
                    end else begin
                        res_data_q <= (op_q == MUL_OP_MUL) ? p_q[31:0] : p_q[63:32];
                        res_tag_q  <= tag_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_data = res_data_q;
    assign res_tag  = res_tag_q;

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: latency, signed/unsigned ops, hold, flush and reset behaviour.
module tb_mul_iter;

    localparam int unsigned TAG_W = 4;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             flush_in = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]      exp_data_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];
    logic [31:0]      last_data;
    logic [TAG_W-1:0] last_tag;

    mul_iter #(.TAG_W(TAG_W)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush_in  (flush_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb, pr;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        pr = ea * eb;
        return (op == 2'b00) ? pr[31:0] : pr[63:32];
    endfunction

    // Returns 1 ns after the acceptance edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input bit push);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        while (req_ready !== 1'b1 && n < 100) begin
            @(posedge clk_in); #1;
            n++;
        end
        n_tests++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL issue_wait: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        @(posedge clk_in); #1;
        req_valid = 1'b0;
        if (push) begin
            exp_data_q.push_back(model(op, a, b));
            exp_tag_q.push_back(tag);
        end
    endtask

    task automatic collect(input string name, input bit consume);
        int n = 0;
        while (res_valid !== 1'b1 && n < 100) begin
            @(posedge clk_in); #1;
            n++;
        end
        n_tests++;
        if (n != 34) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, required 34", name, n);
        end
        n_tests++;
        if (exp_data_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: result with empty queue, required an expected entry", name);
        end else begin
            last_data = exp_data_q.pop_front();
            last_tag  = exp_tag_q.pop_front();
            if (res_data !== last_data || res_tag !== last_tag) begin
                n_fail++;
                $display("FAIL %s_data: got data=%h tag=%h, required data=%h tag=%h",
                         name, res_data, res_tag, last_data, last_tag);
            end
        end
        if (consume) begin
            res_ready = 1'b1;
            @(posedge clk_in); #1;
            res_ready = 1'b0;
            n_tests++;
            if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_handoff: got res_valid=%b req_ready=%b, required 0 1",
                         name, res_valid, req_ready);
            end
        end
    endtask

    task automatic check_idle_zero(input string name);
        n_tests++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'd0 || res_tag !== '0) begin
            n_fail++;
            $display("FAIL %s: got ready=%b valid=%b data=%h tag=%h, required 1 0 0 0",
                     name, req_ready, res_valid, res_data, res_tag);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check_idle_zero("reset");
    endtask

    task automatic test_unsigned();
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 1'b1);
        collect("mulhu_max", 1'b1);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 1'b1);
        collect("mul_max", 1'b1);
    endtask

    task automatic test_signed();
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 4'd3, 1'b1);
        collect("mulh_min", 1'b1);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 4'd4, 1'b1);
        collect("mul_min", 1'b1);
        issue(2'b01, 32'hFFFF_FFF9, 32'd3, 4'd5, 1'b1);
        collect("mulh_neg", 1'b1);
        issue(2'b00, 32'hFFFF_FFF9, 32'd3, 4'd6, 1'b1);
        collect("mul_neg", 1'b1);
    endtask

    task automatic test_mixed_zero();
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 1'b1);
        collect("mulhsu", 1'b1);
        issue(2'b00, 32'd0, 32'h1234_5678, 4'd8, 1'b1);
        collect("mul_zero", 1'b1);
        issue(2'b01, 32'd0, 32'hFFFF_FFFF, 4'd9, 1'b1);
        collect("mulh_negzero", 1'b1);
    endtask

    task automatic test_hold();
        issue(2'b00, 32'd1000, 32'd77, 4'hA, 1'b1);
        collect("hold", 1'b0);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd9;
        req_b     = 32'd11;
        req_tag   = 4'hB;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in); #1;
            n_tests++;
            if (res_data !== last_data || res_tag !== last_tag || req_ready !== 1'b0 ||
                res_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got data=%h tag=%h rdy=%b vld=%b, required %h %h 0 1",
                         i, res_data, res_tag, req_ready, res_valid, last_data, last_tag);
            end
        end
        res_ready = 1'b1;
        @(posedge clk_in); #1;
        res_ready = 1'b0;
        n_tests++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got ready=%b valid=%b, required 1 0", req_ready, res_valid);
        end
        issue(2'b00, 32'd9, 32'd11, 4'hB, 1'b1);
        collect("hold_next", 1'b1);
    endtask

    task automatic test_flush();
        int highs = 0;
        issue(2'b00, 32'd123, 32'd456, 4'd3, 1'b0);
        repeat (15) @(posedge clk_in);
        #1;
        flush_in = 1'b1;
        @(posedge clk_in); #1;
        flush_in = 1'b0;
        n_tests++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got ready=%b valid=%b, required 1 0", req_ready, res_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in); #1;
            if (res_valid === 1'b1) highs++;
        end
        n_tests++;
        if (highs != 0) begin
            n_fail++;
            $display("FAIL flush_no_result: got %0d valid cycles, required 0", highs);
        end
        issue(2'b00, 32'd6, 32'd7, 4'd5, 1'b1);
        collect("flush_after", 1'b1);
    endtask

    task automatic test_reset_mid();
        issue(2'b00, 32'd3, 32'd4, 4'd7, 1'b0);
        repeat (33) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        check_idle_zero("reset_in_fix");
        issue(2'b00, 32'd3, 32'd4, 4'd7, 1'b1);
        collect("pre_reset_done", 1'b0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        check_idle_zero("reset_in_done");
    endtask

    task automatic test_back_to_back();
        issue(2'b00, 32'd3, 32'd4, 4'd1, 1'b1);
        collect("b2b_first", 1'b1);
        issue(2'b00, 32'd5, 32'd5, 4'd2, 1'b1);
        collect("b2b_second", 1'b1);
        n_tests++;
        if (exp_data_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_data_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_mixed_zero();
        test_hold();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
